// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU arbiter: op codes, response FSM state, requester id.
package alu_share_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; prio points at the requester that wins a tie next.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic en,
    output logic gnt0,
    output logic gnt1
);

    logic r_prio;

    assign gnt0 = en & valid0 & (~valid1 | ~r_prio);
    assign gnt1 = en & valid1 & (~valid0 |  r_prio);

    // After a grant the other requester gets priority; gnt0 means id 1 is next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (gnt0 | gnt1) begin
            r_prio <= gnt0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between EX stage (id 0) and branch/address helper (id 1).
// Optional grant/conflict statistics counters enabled with ALU_SHARE_STATS_EN.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 32
`ifdef ALU_SHARE_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req0_sp_sign,
    input  logic             req0_uors,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic             req1_sp_sign,
    input  logic             req1_uors,
    output logic [WIDTH-1:0] alu_a0,
    output logic [WIDTH-1:0] alu_b0,
    output logic [2:0]       alu_op,
    output logic             alu_sp_sign,
    output logic             alu_uors,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [2:0]       alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_zero
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    rsp_state_t       r_state;
    rsp_state_t       w_state_nxt;
    req_id_t          r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic [2:0]       r_rsp_zero;
    logic             w_can_accept;
    logic             w_en;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_hs;

    // Reset is asynchronous, so readies are also masked while it is held.
    assign w_can_accept = (r_state == EMPTY) | rsp_ready;
    assign w_en         = w_can_accept & ~rst;
    assign w_hs         = w_gnt0 | w_gnt1;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .en     (w_en),
        .gnt0   (w_gnt0),
        .gnt1   (w_gnt1)
    );

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        alu_a0      = '0;
        alu_b0      = '0;
        alu_op      = OP_ADD;
        alu_sp_sign = 1'b0;
        alu_uors    = 1'b0;
        if (w_gnt0) begin
            alu_a0      = req0_a;
            alu_b0      = req0_b;
            alu_op      = req0_op;
            alu_sp_sign = req0_sp_sign;
            alu_uors    = req0_uors;
        end else if (w_gnt1) begin
            alu_a0      = req1_a;
            alu_b0      = req1_b;
            alu_op      = req1_op;
            alu_sp_sign = req1_sp_sign;
            alu_uors    = req1_uors;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_hs) w_state_nxt = FULL;
            FULL:    if (rsp_ready && !w_hs) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A handshake always overwrites the register; FULL with backpressure never handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= '0;
        end else if (w_hs) begin
            r_rsp_id     <= w_gnt1;
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
        end
    end

    assign rsp_valid  = (r_state == FULL);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;

`ifdef ALU_SHARE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_grant0_cnt;
    logic [CNT_W-1:0] r_grant1_cnt;
    logic [CNT_W-1:0] r_conflict_cnt;
    logic             w_conflict;

    assign w_conflict = req0_valid & req1_valid & w_en;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant0_cnt   <= '0;
            r_grant1_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_gnt0 && r_grant0_cnt != CNT_MAX)
                r_grant0_cnt <= r_grant0_cnt + CNT_W'(1);
            if (w_gnt1 && r_grant1_cnt != CNT_MAX)
                r_grant1_cnt <= r_grant1_cnt + CNT_W'(1);
            if (w_conflict && r_conflict_cnt != CNT_MAX)
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign grant0_cnt   = r_grant0_cnt;
    assign grant1_cnt   = r_grant1_cnt;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid, req0_ready, req0_sp_sign, req0_uors;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [2:0]       req0_op;
    logic             req1_valid, req1_ready, req1_sp_sign, req1_uors;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] alu_a0, alu_b0, alu_result;
    logic [2:0]       alu_op, alu_zero;
    logic             alu_sp_sign, alu_uors;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic [2:0]       rsp_zero;
`ifdef ALU_SHARE_STATS_EN
    logic [15:0]      grant0_cnt, grant1_cnt, conflict_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_op      (req0_op),
        .req0_sp_sign (req0_sp_sign),
        .req0_uors    (req0_uors),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_op      (req1_op),
        .req1_sp_sign (req1_sp_sign),
        .req1_uors    (req1_uors),
        .alu_a0       (alu_a0),
        .alu_b0       (alu_b0),
        .alu_op       (alu_op),
        .alu_sp_sign  (alu_sp_sign),
        .alu_uors     (alu_uors),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero)
`ifdef ALU_SHARE_STATS_EN
        ,
        .grant0_cnt   (grant0_cnt),
        .grant1_cnt   (grant1_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Behavioural ALU; flags are {a==b, signed a<b, unsigned a<b}.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_sp_sign ? alu_a0 - alu_b0 : alu_a0 + alu_b0;
            OP_SLL:  alu_result = alu_a0 << alu_b0[4:0];
            OP_SLT:  alu_result = WIDTH'($signed(alu_a0) < $signed(alu_b0));
            OP_SLTU: alu_result = WIDTH'(alu_a0 < alu_b0);
            OP_XOR:  alu_result = alu_a0 ^ alu_b0;
            OP_SRL:  alu_result = alu_sp_sign ? $unsigned($signed(alu_a0) >>> alu_b0[4:0])
                                              : alu_a0 >> alu_b0[4:0];
            OP_OR:   alu_result = alu_a0 | alu_b0;
            OP_AND:  alu_result = alu_a0 & alu_b0;
            default: alu_result = '0;
        endcase
        alu_zero = {alu_a0 == alu_b0, $signed(alu_a0) < $signed(alu_b0), alu_a0 < alu_b0};
    end

    // Requester rule watch: fields must not change while valid && !ready.
    logic        stab_bad = 1'b0;
    logic        m_pend0 = 1'b0, m_pend1 = 1'b0;
    logic [68:0] m_f0, m_f1;
    always @(posedge clk) begin
        if (rst) begin
            m_pend0 = 1'b0;
            m_pend1 = 1'b0;
        end else begin
            if (m_pend0 && req0_valid && {req0_a, req0_b, req0_op, req0_sp_sign, req0_uors} !== m_f0) begin
                $display("FAIL stable0 fields changed while waiting at %0t", $time);
                stab_bad = 1'b1;
            end
            if (m_pend1 && req1_valid && {req1_a, req1_b, req1_op, req1_sp_sign, req1_uors} !== m_f1) begin
                $display("FAIL stable1 fields changed while waiting at %0t", $time);
                stab_bad = 1'b1;
            end
            m_pend0 = req0_valid && !req0_ready;
            m_pend1 = req1_valid && !req1_ready;
            m_f0 = {req0_a, req0_b, req0_op, req0_sp_sign, req0_uors};
            m_f1 = {req1_a, req1_b, req1_op, req1_sp_sign, req1_uors};
        end
    end

    task automatic set0(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic sp, input logic u);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_sp_sign = sp; req0_uors = u;
    endtask

    task automatic set1(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic sp, input logic u);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_sp_sign = sp; req1_uors = u;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        set0(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
        set1(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set0(1'b1, 32'd7, 32'd1, 3'd0, 1'b0, 1'b0);
        set1(1'b1, 32'd9, 32'd2, 3'd0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", rsp_valid); else n_pass++;
        n_total++; if (rsp_id !== 1'b0) $display("FAIL rst_id got=%0b exp=0", rsp_id); else n_pass++;
        n_total++; if (rsp_result !== 32'd0) $display("FAIL rst_result got=%0h exp=0", rsp_result); else n_pass++;
        n_total++; if (rsp_zero !== 3'd0) $display("FAIL rst_zero got=%0b exp=0", rsp_zero); else n_pass++;
        n_total++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL rst_ready got=%0b exp=00", {req0_ready, req1_ready}); else n_pass++;
        n_total++; if (alu_a0 !== 32'd0) $display("FAIL rst_alu_a got=%0h exp=0", alu_a0); else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        set0(1'b1, 32'd5, 32'd3, 3'b000, 1'b1, 1'b0);
        rsp_ready = 1'b1;
        #1;
        n_total++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_ready got=%0b exp=10", {req0_ready, req1_ready}); else n_pass++;
        n_total++; if ({alu_a0, alu_b0} !== {32'd5, 32'd3}) $display("FAIL single_alu_ops got=%0h/%0h exp=5/3", alu_a0, alu_b0); else n_pass++;
        n_total++; if ({alu_op, alu_sp_sign} !== 4'b0001) $display("FAIL single_alu_ctl got=%0b exp=0001", {alu_op, alu_sp_sign}); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid got=%0b exp=0", rsp_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL single_valid got=%0b exp=1", rsp_valid); else n_pass++;
        n_total++; if (rsp_result !== 32'd2) $display("FAIL single_result got=%0h exp=2", rsp_result); else n_pass++;
        n_total++; if (rsp_id !== 1'b0) $display("FAIL single_id got=%0b exp=0", rsp_id); else n_pass++;
        @(negedge clk);
        set0(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
        #1;
        n_total++; if ({alu_a0, alu_op} !== 35'd0) $display("FAIL idle_alu got=%0h/%0b exp=0/0", alu_a0, alu_op); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL drain_valid got=%0b exp=0", rsp_valid); else n_pass++;
        n_total++; if (rsp_result !== 32'd2) $display("FAIL drain_hold got=%0h exp=2", rsp_result); else n_pass++;
    endtask

    task automatic test_conflict();
        logic exp_id;
        apply_reset();
        @(negedge clk);
        set0(1'b1, 32'd10, 32'd1, 3'b000, 1'b0, 1'b0);
        set1(1'b1, 32'd20, 32'd2, 3'b100, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2) == 1;
            if (i > 0) @(negedge clk);
            #1;
            n_total++; if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) $display("FAIL conflict_ready[%0d] got=%0b exp=%0b", i, {req0_ready, req1_ready}, {~exp_id, exp_id}); else n_pass++;
            @(posedge clk); #1;
            n_total++; if ({rsp_valid, rsp_id} !== {1'b1, exp_id}) $display("FAIL conflict_id[%0d] got=%0b exp=%0b", i, {rsp_valid, rsp_id}, {1'b1, exp_id}); else n_pass++;
            n_total++; if (rsp_result !== (exp_id ? 32'd22 : 32'd11)) $display("FAIL conflict_result[%0d] got=%0d exp=%0d", i, rsp_result, exp_id ? 22 : 11); else n_pass++;
        end
        @(negedge clk);
        set0(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
        set1(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        set0(1'b1, 32'd10, 32'd1, 3'b000, 1'b0, 1'b0);
        set1(1'b1, 32'd20, 32'd2, 3'b100, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_total++; if ({rsp_id, rsp_result} !== {1'b0, 32'd11}) $display("FAIL bp_first got=%0b/%0d exp=0/11", rsp_id, rsp_result); else n_pass++;
        @(negedge clk);
        rsp_ready = 1'b0;
        repeat (3) begin
            #1;
            n_total++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_ready got=%0b exp=00", {req0_ready, req1_ready}); else n_pass++;
            n_total++; if (alu_a0 !== 32'd0) $display("FAIL bp_alu_idle got=%0h exp=0", alu_a0); else n_pass++;
            @(posedge clk); #1;
            n_total++; if ({rsp_valid, rsp_result} !== {1'b1, 32'd11}) $display("FAIL bp_hold got=%0b/%0d exp=1/11", rsp_valid, rsp_result); else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_total++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL bp_release_ready got=%0b exp=01", {req0_ready, req1_ready}); else n_pass++;
        n_total++; if (alu_a0 !== 32'd20) $display("FAIL bp_release_alu got=%0d exp=20", alu_a0); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'd22}) $display("FAIL bp_release_rsp got=%0b/%0b/%0d exp=1/1/22", rsp_valid, rsp_id, rsp_result); else n_pass++;
        @(negedge clk);
        set0(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
        set1(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_compare();
        apply_reset();
        @(negedge clk);
        set1(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        #1;
        n_total++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL cmp_ready got=%0b exp=01", {req0_ready, req1_ready}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({rsp_id, rsp_result} !== {1'b1, 32'd1}) $display("FAIL slt_result got=%0b/%0h exp=1/1", rsp_id, rsp_result); else n_pass++;
        n_total++; if (rsp_zero !== 3'b010) $display("FAIL slt_flags got=%0b exp=010", rsp_zero); else n_pass++;
        @(negedge clk);
        set1(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b011, 1'b0, 1'b1);
        #1;
        n_total++; if ({alu_op, alu_uors} !== 4'b0111) $display("FAIL sltu_alu_ctl got=%0b exp=0111", {alu_op, alu_uors}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_result !== 32'd0) $display("FAIL sltu_result got=%0h exp=0", rsp_result); else n_pass++;
        n_total++; if (rsp_zero !== 3'b010) $display("FAIL sltu_flags got=%0b exp=010", rsp_zero); else n_pass++;
        @(negedge clk);
        set1(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        set0(1'b1, 32'd5, 32'd3, 3'b000, 1'b1, 1'b0);
        set1(1'b1, 32'd20, 32'd2, 3'b100, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        n_total++; if ({rsp_valid, rsp_result} !== {1'b1, 32'd2}) $display("FAIL mid_full got=%0b/%0d exp=1/2", rsp_valid, rsp_result); else n_pass++;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        n_total++; if ({rsp_valid, rsp_result} !== {1'b0, 32'd0}) $display("FAIL mid_async_clear got=%0b/%0d exp=0/0", rsp_valid, rsp_result); else n_pass++;
        n_total++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL mid_rst_ready got=%0b exp=00", {req0_ready, req1_ready}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL mid_prio_reset got=%0b exp=10", {req0_ready, req1_ready}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({rsp_valid, rsp_id} !== 2'b10) $display("FAIL mid_after_id got=%0b exp=10", {rsp_valid, rsp_id}); else n_pass++;
        @(negedge clk);
        set0(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
        set1(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
    endtask

`ifdef ALU_SHARE_STATS_EN
    task automatic test_stats();
        apply_reset();
        #1;
        n_total++; if ({grant0_cnt, grant1_cnt, conflict_cnt} !== 48'd0) $display("FAIL stats_reset got=%0h exp=0", {grant0_cnt, grant1_cnt, conflict_cnt}); else n_pass++;
        @(negedge clk);
        set0(1'b1, 32'd1, 32'd1, 3'b000, 1'b0, 1'b0);
        set1(1'b1, 32'd2, 32'd2, 3'b000, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        repeat (66000) @(posedge clk);
        @(negedge clk);
        #1;
        n_total++; if (conflict_cnt !== 16'hFFFF) $display("FAIL stats_conflict_sat got=%0h exp=ffff", conflict_cnt); else n_pass++;
        n_total++; if (grant0_cnt !== 16'd33000) $display("FAIL stats_grant0 got=%0d exp=33000", grant0_cnt); else n_pass++;
        n_total++; if (grant1_cnt !== 16'd33000) $display("FAIL stats_grant1 got=%0d exp=33000", grant1_cnt); else n_pass++;
        repeat (10) @(posedge clk);
        #1;
        n_total++; if (conflict_cnt !== 16'hFFFF) $display("FAIL stats_conflict_hold got=%0h exp=ffff", conflict_cnt); else n_pass++;
        @(negedge clk);
        set0(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
        set1(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_protocol();
        n_total++; if (stab_bad !== 1'b0) $display("FAIL requester_stability got=%0b exp=0", stab_bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_backpressure();
        test_compare();
        test_reset_mid();
`ifdef ALU_SHARE_STATS_EN
        test_stats();
`endif
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
